// File: rtl/ca_row_engine_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ca_row_engine_if : control request and image-RAM port bundle
// Rev 1.0
// ------------------------------------------------------------------
interface ca_row_engine_if #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              mode;
  logic              direction;
  logic [7:0]        rule;
  logic              read;
  logic [ADDR_W-1:0] raddr;
  logic [WORD_W-1:0] rdata;
  logic              write;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              busy;
  logic              done;

  modport slave (
    input  start, mode, direction, rule, rdata,
    output read, raddr, write, waddr, wdata, busy, done
  );

  modport master (
    output start, mode, direction, rule, rdata,
    input  read, raddr, write, waddr, wdata, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ca_row_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// ca_row_engine : elementary CA row evolve / centre-seed engine
// Rev 1.0
// ------------------------------------------------------------------
module ca_row_engine #(
  parameter int WORD_W = 16,
  parameter int WORDS  = 16,
  parameter int WRAP   = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ca_row_engine_if.slave bus
);
  localparam int IDX_W  = $clog2(WORDS);
  localparam int ADDR_W = 1 + IDX_W;
  localparam logic [IDX_W:0] C_LAST = (IDX_W+1)'(WORDS);
  localparam logic [IDX_W:0] C_HALF = (IDX_W+1)'(WORDS / 2);
  localparam logic [IDX_W:0] C_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] C_TWO  = (IDX_W+1)'(2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_SEED  = 3'd4
  } state_t;

  state_t            r_state;
  logic [7:0]        r_rule;
  logic              r_dir;
  logic [IDX_W:0]    r_idx;
  logic              r_left;
  logic [WORD_W-1:0] r_cur;
  logic              r_bit0;
  logic              r_read;
  logic              r_write;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W-1:0] r_waddr;
  logic [WORD_W-1:0] r_wdata;

  logic              w_right;
  logic [WORD_W+1:0] w_ext;
  logic [WORD_W-1:0] w_word;
  logic [IDX_W-1:0]  w_widx;

  // Window {right, current word, left}; cell i sees ext[i+2:i] as {r, c, l}.
  always_comb begin
    w_right = bus.rdata[0];
    if (r_state == S_FLUSH)
      w_right = (WRAP != 0) && r_bit0;
    w_ext  = {w_right, r_cur, r_left};
    w_word = '0;
    for (int i = 0; i < WORD_W; i++)
      w_word[i] = r_rule[{w_ext[i], w_ext[i+1], w_ext[i+2]}];
  end

  assign w_widx = r_idx[IDX_W-1:0] - IDX_W'(2);

  assign bus.read  = r_read;
  assign bus.raddr = r_raddr;
  assign bus.write = r_write;
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rule  <= '0;
      r_dir   <= 1'b0;
      r_idx   <= '0;
      r_left  <= 1'b0;
      r_cur   <= '0;
      r_bit0  <= 1'b0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !r_done) begin
            r_rule <= bus.rule;
            r_dir  <= bus.direction;
            r_busy <= 1'b1;
            r_idx  <= '0;
            if (bus.mode) begin
              r_state <= S_SEED;
              r_write <= 1'b1;
              r_waddr <= {~bus.direction, {IDX_W{1'b0}}};
              r_wdata <= '0;
              r_idx   <= C_ONE;
            end else begin
              r_state <= S_PRE;
              r_read  <= 1'b1;
              r_raddr <= {bus.direction, {IDX_W{1'b1}}};
            end
          end
        end
        S_PRE: begin
          r_cur   <= (WRAP != 0) ? bus.rdata : '0;
          r_raddr <= {r_dir, {IDX_W{1'b0}}};
          r_idx   <= C_ONE;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // r_idx equals the index of the word arriving on rdata plus one.
          r_left <= r_cur[WORD_W-1];
          r_cur  <= bus.rdata;
          if (r_idx == C_ONE)
            r_bit0 <= bus.rdata[0];
          if (r_idx >= C_TWO) begin
            r_write <= 1'b1;
            r_waddr <= {~r_dir, w_widx};
            r_wdata <= w_word;
          end
          if (r_idx == C_LAST) begin
            r_read  <= 1'b0;
            r_idx   <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_raddr <= {r_dir, r_idx[IDX_W-1:0]};
            r_idx   <= r_idx + C_ONE;
          end
        end
        S_FLUSH: begin
          if (r_idx == '0) begin
            r_waddr <= {~r_dir, {IDX_W{1'b1}}};
            r_wdata <= w_word;
            r_idx   <= C_ONE;
          end else begin
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_SEED: begin
          if (r_idx == C_LAST) begin
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_waddr <= {~r_dir, r_idx[IDX_W-1:0]};
            r_wdata <= (r_idx == C_HALF) ? WORD_W'(1) : '0;
            r_idx   <= r_idx + C_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_ca_row_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ca_row_engine : drives WRAP=0 and WRAP=1 engines side by side
// Rev 1.0
// ------------------------------------------------------------------
module tb_ca_row_engine;
  localparam int WORD_W = 16;
  localparam int WORDS  = 16;
  localparam int ADDR_W = 5;
  localparam int NB     = 2 * WORDS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ca_row_engine_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus_n ();
  ca_row_engine_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus_w ();

  ca_row_engine #(.WORD_W(WORD_W), .WORDS(WORDS), .WRAP(0)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );
  ca_row_engine #(.WORD_W(WORD_W), .WORDS(WORDS), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w)
  );

  logic       t_start, t_mode, t_dir;
  logic [7:0] t_rule;
  assign bus_n.start = t_start;  assign bus_w.start = t_start;
  assign bus_n.mode  = t_mode;   assign bus_w.mode  = t_mode;
  assign bus_n.direction = t_dir; assign bus_w.direction = t_dir;
  assign bus_n.rule  = t_rule;   assign bus_w.rule  = t_rule;

  // Image RAMs (index 0 = WRAP 0 engine, 1 = WRAP 1 engine), clocked on !clk
  logic [15:0] mem    [2][NB];
  logic [15:0] pl_img [2][NB];
  logic        pl_req = 1'b0;
  int          wcnt   [2] = '{0, 0};

  always @(negedge clk) begin
    if (pl_req) begin
      for (int a = 0; a < NB; a++) begin
        mem[0][a] <= pl_img[0][a];
        mem[1][a] <= pl_img[1][a];
      end
    end else begin
      if (bus_n.read) bus_n.rdata <= mem[0][bus_n.raddr];
      if (bus_w.read) bus_w.rdata <= mem[1][bus_w.raddr];
      if (bus_n.write) begin
        mem[0][bus_n.waddr] <= bus_n.wdata;
        wcnt[0] <= wcnt[0] + 1;
      end
      if (bus_w.write) begin
        mem[1][bus_w.waddr] <= bus_w.wdata;
        wcnt[1] <= wcnt[1] + 1;
      end
    end
  end

  int           n_chk = 0;
  int           n_pass = 0;
  logic         cur_mode, cur_dir;
  logic [255:0] cur_exp [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: next generation computed cell by cell from the rule table.
  function automatic logic [255:0] evolve(input logic [255:0] row, input logic [7:0] rule, input bit wrap);
    logic [255:0] nx;
    logic l, m, r;
    for (int c = 0; c < 256; c++) begin
      l = (c == 0)   ? (wrap ? row[255] : 1'b0) : row[c-1];
      m = row[c];
      r = (c == 255) ? (wrap ? row[0] : 1'b0)   : row[c+1];
      nx[c] = rule[int'(l) * 4 + int'(m) * 2 + int'(r)];
    end
    return nx;
  endfunction

  function automatic logic [255:0] get_bank(input int k, input logic b);
    logic [255:0] r;
    for (int w = 0; w < WORDS; w++) r[16*w +: 16] = mem[k][int'(b) * WORDS + w];
    return r;
  endfunction

  function automatic logic [255:0] rnd_row();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic load_banks(input logic [255:0] b0, input logic [255:0] b1);
    for (int k = 0; k < 2; k++)
      for (int w = 0; w < WORDS; w++) begin
        pl_img[k][w]         = b0[16*w +: 16];
        pl_img[k][WORDS + w] = b1[16*w +: 16];
      end
    pl_req = 1'b1;
    @(negedge clk);
    #1 pl_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " n.read"},  bus_n.read,  0);  chk({tag, " w.read"},  bus_w.read,  0);
    chk({tag, " n.write"}, bus_n.write, 0);  chk({tag, " w.write"}, bus_w.write, 0);
    chk({tag, " n.busy"},  bus_n.busy,  0);  chk({tag, " w.busy"},  bus_w.busy,  0);
    chk({tag, " n.done"},  bus_n.done,  0);  chk({tag, " w.done"},  bus_w.done,  0);
    chk({tag, " n.raddr"}, bus_n.raddr, 0);  chk({tag, " w.raddr"}, bus_w.raddr, 0);
    chk({tag, " n.waddr"}, bus_n.waddr, 0);  chk({tag, " w.waddr"}, bus_w.waddr, 0);
    chk({tag, " n.wdata"}, bus_n.wdata, 0);  chk({tag, " w.wdata"}, bus_w.wdata, 0);
  endtask

  task automatic chk_cycle(input int k, input int c, input logic rd, input logic [4:0] ra,
                           input logic wr, input logic [4:0] wa, input logic [15:0] wd,
                           input logic bsy, input logic dn);
    logic e_rd, e_wr, e_bsy, e_dn;
    logic [4:0] e_ra;
    int wi;
    if (cur_mode) begin
      e_rd = 1'b0; e_ra = '0; wi = c;
      e_wr = (c < WORDS); e_bsy = (c < WORDS); e_dn = (c == WORDS);
    end else begin
      e_rd = (c <= WORDS);
      e_ra = (c == 0) ? {cur_dir, 4'hF} : {cur_dir, 4'(c - 1)};
      wi = c - 3;
      e_wr = (c >= 3) && (c <= WORDS + 2); e_bsy = (c <= WORDS + 2); e_dn = (c == WORDS + 3);
    end
    chk($sformatf("read d%0d c%0d", k, c), rd, e_rd);
    if (e_rd) chk($sformatf("raddr d%0d c%0d", k, c), ra, e_ra);
    chk($sformatf("write d%0d c%0d", k, c), wr, e_wr);
    if (e_wr) begin
      chk($sformatf("waddr d%0d c%0d", k, c), wa, {~cur_dir, 4'(wi)});
      chk($sformatf("wdata d%0d c%0d", k, c), wd, cur_exp[k][16*wi +: 16]);
    end
    chk($sformatf("busy d%0d c%0d", k, c), bsy, e_bsy);
    chk($sformatf("done d%0d c%0d", k, c), dn, e_dn);
  endtask

  task automatic run(input logic mode, input logic dir, input logic [7:0] rule,
                     input bit perturb, input int rst_cyc);
    logic [255:0] src [2];
    int w0 [2];
    int done_c;
    for (int k = 0; k < 2; k++) begin
      src[k]     = get_bank(k, dir);
      cur_exp[k] = mode ? (256'd1 << 128) : evolve(src[k], rule, k == 1);
      w0[k]      = wcnt[k];
    end
    cur_mode = mode;
    cur_dir  = dir;
    done_c   = mode ? WORDS : WORDS + 3;
    @(negedge clk);
    t_start = 1'b1; t_mode = mode; t_dir = dir; t_rule = rule;
    @(posedge clk);
    #1 t_start = 1'b0;
    for (int c = 0; c <= done_c + 2; c++) begin
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        for (int r = 0; r < 6; r++) begin
          chk_quiet($sformatf("rst r%0d", r));
          if (r == 2) rst = 1'b0;
          @(posedge clk);
          #1;
        end
        for (int k = 0; k < 2; k++)
          chk($sformatf("rst wcount d%0d", k), wcnt[k] - w0[k], rst_cyc - 3);
        return;
      end
      chk_cycle(0, c, bus_n.read, bus_n.raddr, bus_n.write, bus_n.waddr, bus_n.wdata, bus_n.busy, bus_n.done);
      chk_cycle(1, c, bus_w.read, bus_w.raddr, bus_w.write, bus_w.waddr, bus_w.wdata, bus_w.busy, bus_w.done);
      if (perturb && c == 5) begin
        t_start = 1'b1; t_rule = ~rule; t_mode = ~mode; t_dir = ~dir;
      end
      if (perturb && c == 6) begin
        t_start = 1'b0; t_rule = rule; t_mode = mode; t_dir = dir;
      end
      if (c == done_c) begin
        t_start = 1'b1; t_mode = 1'b1;
      end
      if (c == done_c + 1) begin
        t_start = 1'b0; t_mode = mode;
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wcount d%0d", k), wcnt[k] - w0[k], WORDS);
      for (int w = 0; w < WORDS; w++) begin
        chk($sformatf("bank%0d d%0d w%0d", int'(~dir), k, w),
            mem[k][int'(~dir) * WORDS + w], cur_exp[k][16*w +: 16]);
        chk($sformatf("src d%0d w%0d", k, w), mem[k][int'(dir) * WORDS + w], src[k][16*w +: 16]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    t_start = 1'b0; t_mode = 1'b0; t_dir = 1'b0; t_rule = 8'd0;
    repeat (2) @(posedge clk);
    #1 chk_quiet("reset");
    @(negedge clk) rst = 1'b0;

    load_banks('0, '0);
    run(1'b1, 1'b0, 8'd0, 0, -1);
    run(1'b1, 1'b1, 8'd0, 0, -1);
    run(1'b0, 1'b0, 8'd90, 0, -1);
    run(1'b1, 1'b1, 8'd0, 0, -1);
    run(1'b0, 1'b0, 8'd30, 1, -1);

    load_banks(256'd1, '0);
    run(1'b0, 1'b0, 8'd90, 0, -1);
    load_banks('0, '0);
    run(1'b0, 1'b0, 8'd255, 0, -1);
    load_banks('0, '0);
    run(1'b0, 1'b0, 8'd1, 0, -1);
    load_banks('1, '0);
    run(1'b0, 1'b0, 8'd0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      load_banks(rnd_row(), rnd_row());
      run(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), i == 2, -1);
    end
    run(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 0, -1);

    load_banks(rnd_row(), rnd_row());
    run(1'b0, 1'b0, 8'($urandom_range(0, 255)), 0, 6);
    load_banks(rnd_row(), rnd_row());
    run(1'b0, 1'b1, 8'd110, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ca_row_engine.md
# ca_row_engine

Parametrised elementary cellular-automaton row engine: reads the current generation from the image RAM's read bank, applies any of the 256 Wolfram rules, and writes the next generation into the opposite bank. It also has a seed mode that writes a single centre cell, so one block covers both row generation and row initialisation. It sits between the VGA sync counters, which issue `start` during horizontal blanking, and the dual-port image RAM. That RAM is clocked on `!clk` and returns read data one `clk` cycle after the read is issued.

## Interface
- `WORD_W`, 16: cells per RAM word.
- `WORDS`, 16: words per row; power of two, ≥ 4.
- `WRAP`, 1: boundary mode. 1 = toroidal; 0 = cells outside the row read as 0.
- `ADDR_W`, 1+log2(`WORDS`): derived; address = {bank, word index}.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `mode`  in  1  0 = evolve, 1 = seed; sampled with `start`.
- `direction`  in  1  read bank; the write bank is `!direction`. Sampled with `start`.
- `rule`  in  8  Wolfram rule number; sampled with `start`.
- `read`  out  1  RAM read enable.
- `raddr`  out  ADDR_W  read address.
- `rdata`  in  WORD_W  RAM read data; valid in the cycle after `read`.
- `write`  out  1  RAM write enable.
- `waddr`  out  ADDR_W  write address.
- `wdata`  out  WORD_W  write data.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Cell c of a row is bit (c mod `WORD_W`) of word c/`WORD_W`. Left neighbour = c−1; right neighbour = c+1.
- Next cell value = `rule`[{left, centre, right}], with left as the MSB of the index.
- States and transitions:
  - IDLE → PRE on `start` with `mode`=0.
  - IDLE → SEED on `start` with `mode`=1.
  - PRE → RUN → FLUSH → IDLE.
  - SEED → IDLE.
- PRE: reads word `WORDS`−1 to obtain the left neighbour of cell 0. When `WRAP`=0 the fetched value is ignored and the neighbour is 0.
- RUN: reads words 0..`WORDS`−1 in order. Holds a three-word window (previous, current, next). Writes word w once word w+1 has arrived.
- FLUSH: computes word `WORDS`−1. Its right neighbour is the saved bit 0 of word 0 when `WRAP`=1, or 0 when `WRAP`=0.
- SEED: writes words 0..`WORDS`−1 with no reads. Word `WORDS`/2 = 1 (bit 0 set); all other words = 0.
- `rule`, `mode` and `direction` are latched at start. Input changes while busy have no effect.
- `start` while busy is ignored. `start` in the same cycle as `done` is ignored; it is accepted from the next cycle.
- Reset, including mid-run: all outputs 0, state IDLE, no further writes. A partially written bank is left as is.

## Timing
- Cycle 0 = the first cycle after the rising edge that accepts `start`.
- All outputs are registered. Reset values: `read`=`write`=`busy`=`done`=0, `raddr`=`waddr`=0, `wdata`=0.
- Evolve reads: `read`=1 in cycles 0..`WORDS`. Cycle 0 reads address {dir, `WORDS`−1}; cycle k reads {dir, k−1}.
- Evolve writes: `write`=1 in cycles 3..`WORDS`+2. Cycle w+3 writes address {!dir, w}.
- Evolve end: `busy`=1 in cycles 0..`WORDS`+2; `done`=1 in cycle `WORDS`+3.
- Seed: `write`=1 in cycles 0..`WORDS`−1 at address {!dir, k}. `busy` = 1 over the same cycles; `done` in cycle `WORDS`.
- `read` and `write` are never both asserted for the same bank.
- A full evolve takes `WORDS`+4 cycles, which must fit inside horizontal blanking.

## Test plan
- Seed, `direction`=0, defaults -> bank 1 word 8 = 16'h0001, every other word 16'h0000; exactly 16 writes; `done` in cycle 16.
- Seed in bank 0, then evolve with `rule`=90, `direction`=0 -> bank 1 word 7 = 16'h8000, word 8 = 16'h0002, rest 0; `done` in cycle 19.
- Same seed, `rule`=30 -> word 7 = 16'h8000, word 8 = 16'h0003, rest 0.
- Bank 0 preloaded with word 0 = 16'h0001 and the rest 0, `rule`=90:
  - `WRAP`=1 -> word 0 = 16'h0002, word 15 = 16'h8000.
  - `WRAP`=0 -> word 0 = 16'h0002, word 15 = 16'h0000.
- Rule corner cases on an all-zero bank:
  - `rule`=255 -> every word 16'hFFFF.
  - `rule`=1 -> every word 16'hFFFF.
  - `rule`=0 on an all-ones bank -> every word 16'h0000.
- Robustness:
  - Change `rule` and pulse `start` mid-run -> result and timing unchanged.
  - Assert `rst` in cycle 6 -> `write`, `busy` and `done` are 0 immediately and stay 0 until the next `start`.
